fp_accumulate: RTL and testbench

- Sequential IEEE-754 single-precision accumulator that sits directly downstream of the FP multiplier.
- Each accepted product (the multiplier's mul_result) is added into a running 32-bit FP sum.
- Together with the multiplier it forms the multiply-accumulate datapath. The start/done handshake mirrors the multiplier's, so the multiplier's done pulse can drive acc_start directly.

---
 rtl/fp_pkg.sv | 36 +++
 rtl/fp_align_shift.sv | 20 ++
 rtl/fp_accumulate.sv | 200 ++++++++++++++++++++
 tb/tb_fp_accumulate.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared FP32 definitions for the multiply-accumulate datapath.
// Field widths, the unpacked struct view of a word and the accumulator state encoding.
package fp_pkg;

    localparam int EXP_W    = 8;
    localparam int FRAC_W   = 23;
    localparam int MANT_W   = 24;
    localparam int EXP_BIAS = 127;
    localparam int EXP_MAX  = 255;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [FRAC_W-1:0] frac;
    } fp32_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ALIGN = 3'd1,
        ADD   = 3'd2,
        NORM  = 3'd3,
        DONE  = 3'd4
    } acc_state_t;

    // Denormals are flushed: a zero exponent means an exact zero mantissa.
    function automatic logic [MANT_W-1:0] unpack_mant(input fp32_t v);
        logic [MANT_W-1:0] m;
        if (v.exp == 8'd0) begin
            m = 24'd0;
        end else begin
            m = {1'b1, v.frac};
        end
        return m;
    endfunction

endpackage

// File: rtl/fp_align_shift.sv
// Mantissa alignment shifter: right shift by an exponent difference.
// Amounts of 24 or more push every significant bit out, giving zero.
module fp_align_shift
    import fp_pkg::*;
(
    input  logic [MANT_W-1:0] mant_in,
    input  logic [7:0]        amount,
    output logic [MANT_W-1:0] mant_out
);

    // Truncating shift with saturation to zero
    always_comb begin
        if (amount >= 8'd24) begin
            mant_out = 24'd0;
        end else begin
            mant_out = mant_in >> amount;
        end
    end

endmodule

// File: rtl/fp_accumulate.sv
// Sequential FP32 accumulator: adds each accepted product into a running sum
// over ALIGN/ADD/NORM/DONE, truncating, with a sticky overflow flag.
module fp_accumulate
    import fp_pkg::*;
#(
    parameter bit SAT_ON_OVF = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        acc_clear,
    input  logic        acc_start,
    input  logic [31:0] acc_in,
    output logic        acc_busy,
    output logic        acc_done,
    output logic        acc_overflow,
    output logic [31:0] acc_sum
);

    acc_state_t        state_r;
    fp32_t             op_a_r;
    fp32_t             op_b_r;
    logic [MANT_W-1:0] big_mant_r;
    logic [MANT_W-1:0] small_mant_r;
    logic [7:0]        big_exp_r;
    logic              big_sign_r;
    logic              sub_r;
    logic              ovf_in_r;
    logic              in_sign_r;
    logic [MANT_W-1:0] res_mant_r;
    logic [8:0]        res_exp_r;
    logic              res_sign_r;
    logic              ovf_pend_r;
    logic [31:0]       sum_r;
    logic              done_r;
    logic              ovf_r;

    logic [MANT_W-1:0] a_mant_s;
    logic [MANT_W-1:0] b_mant_s;
    logic              a_big_s;
    logic [MANT_W-1:0] big_mant_s;
    logic [MANT_W-1:0] small_mant_s;
    logic [MANT_W-1:0] small_shifted_s;
    logic [7:0]        big_exp_s;
    logic [7:0]        small_exp_s;
    logic              big_sign_s;
    logic [7:0]        shift_amt_s;

    logic [MANT_W:0]   add_sum_s;
    logic [MANT_W-1:0] add_mant_s;
    logic [8:0]        add_exp_s;
    logic              add_sign_s;
    logic              add_ovf_s;
    logic              norm_exit_s;

    // Order operands by magnitude (exponent, then mantissa)
    always_comb begin
        a_mant_s = unpack_mant(op_a_r);
        b_mant_s = unpack_mant(op_b_r);
        a_big_s  = ({op_a_r.exp, a_mant_s} >= {op_b_r.exp, b_mant_s});
        if (a_big_s) begin
            big_mant_s   = a_mant_s;
            big_exp_s    = op_a_r.exp;
            big_sign_s   = op_a_r.sign;
            small_mant_s = b_mant_s;
            small_exp_s  = op_b_r.exp;
        end else begin
            big_mant_s   = b_mant_s;
            big_exp_s    = op_b_r.exp;
            big_sign_s   = op_b_r.sign;
            small_mant_s = a_mant_s;
            small_exp_s  = op_a_r.exp;
        end
        shift_amt_s = big_exp_s - small_exp_s;
    end

    fp_align_shift u_align (
        .mant_in  (small_mant_s),
        .amount   (shift_amt_s),
        .mant_out (small_shifted_s)
    );

    // Magnitude add/subtract with carry renormalisation and overflow detection
    always_comb begin
        if (sub_r) begin
            add_sum_s = {1'b0, big_mant_r} - {1'b0, small_mant_r};
        end else begin
            add_sum_s = {1'b0, big_mant_r} + {1'b0, small_mant_r};
        end
        add_sign_s = ovf_in_r ? in_sign_r : big_sign_r;
        if (add_sum_s[MANT_W]) begin
            add_mant_s = add_sum_s[MANT_W:1];
            add_exp_s  = {1'b0, big_exp_r} + 9'd1;
        end else begin
            add_mant_s = add_sum_s[MANT_W-1:0];
            add_exp_s  = {1'b0, big_exp_r};
        end
        if (add_mant_s == 24'd0 && !ovf_in_r) begin
            add_exp_s  = 9'd0;
            add_sign_s = 1'b0;
        end else begin
            add_sign_s = add_sign_s;
        end
        add_ovf_s = ovf_in_r | (add_exp_s >= 9'd255);
    end

    assign norm_exit_s = res_mant_r[MANT_W-1] | (res_mant_r == 24'd0) | ovf_pend_r;

    // Sequencer and datapath registers
    always_ff @(posedge clk) begin
        if (rst || acc_clear) begin
            state_r      <= IDLE;
            op_a_r       <= '0;
            op_b_r       <= '0;
            big_mant_r   <= 24'd0;
            small_mant_r <= 24'd0;
            big_exp_r    <= 8'd0;
            big_sign_r   <= 1'b0;
            sub_r        <= 1'b0;
            ovf_in_r     <= 1'b0;
            in_sign_r    <= 1'b0;
            res_mant_r   <= 24'd0;
            res_exp_r    <= 9'd0;
            res_sign_r   <= 1'b0;
            ovf_pend_r   <= 1'b0;
            sum_r        <= 32'h0000_0000;
            done_r       <= 1'b0;
            ovf_r        <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (acc_start) begin
                        op_a_r  <= acc_in;
                        op_b_r  <= sum_r;
                        state_r <= ALIGN;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                ALIGN: begin
                    big_mant_r   <= big_mant_s;
                    small_mant_r <= small_shifted_s;
                    big_exp_r    <= big_exp_s;
                    big_sign_r   <= big_sign_s;
                    sub_r        <= op_a_r.sign ^ op_b_r.sign;
                    ovf_in_r     <= (op_a_r.exp == 8'hFF);
                    in_sign_r    <= op_a_r.sign;
                    state_r      <= ADD;
                end
                ADD: begin
                    res_mant_r <= add_mant_s;
                    res_exp_r  <= add_exp_s;
                    res_sign_r <= add_sign_s;
                    ovf_pend_r <= add_ovf_s;
                    state_r    <= NORM;
                end
                NORM: begin
                    if (norm_exit_s) begin
                        state_r <= DONE;
                        done_r  <= 1'b1;
                        // A set flag freezes the sum until the next clear
                        if (!ovf_r) begin
                            if (ovf_pend_r) begin
                                ovf_r <= 1'b1;
                                if (SAT_ON_OVF) begin
                                    sum_r <= {res_sign_r, 8'hFF, 23'h0};
                                end else begin
                                    sum_r <= sum_r;
                                end
                            end else begin
                                sum_r <= {res_sign_r, res_exp_r[7:0], res_mant_r[MANT_W-2:0]};
                            end
                        end else begin
                            sum_r <= sum_r;
                        end
                    end else if (res_exp_r <= 9'd1) begin
                        res_mant_r <= 24'd0;
                        res_exp_r  <= 9'd0;
                        res_sign_r <= 1'b0;
                    end else begin
                        res_mant_r <= {res_mant_r[MANT_W-2:0], 1'b0};
                        res_exp_r  <= res_exp_r - 9'd1;
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign acc_busy     = (state_r != IDLE);
    assign acc_done     = done_r;
    assign acc_overflow = ovf_r;
    assign acc_sum      = sum_r;

endmodule

// File: tb/tb_fp_accumulate.sv
// Directed self-checking bench for fp_accumulate with hand-computed FP32 results.
module tb_fp_accumulate;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        acc_clear = 1'b0;
    logic        acc_start = 1'b0;
    logic [31:0] acc_in = 32'h0;
    logic        acc_busy;
    logic        acc_done;
    logic        acc_overflow;
    logic [31:0] acc_sum;

    int total = 0;
    int passed = 0;

    fp_accumulate #(.SAT_ON_OVF(1'b1)) dut (
        .clk          (clk),
        .rst          (rst),
        .acc_clear    (acc_clear),
        .acc_start    (acc_start),
        .acc_in       (acc_in),
        .acc_busy     (acc_busy),
        .acc_done     (acc_done),
        .acc_overflow (acc_overflow),
        .acc_sum      (acc_sum)
    );

    always #5 clk = ~clk;

    // Issue one add and return the cycle in which acc_done appeared (0 = never)
    task automatic do_op(input logic [31:0] v, output int lat);
        lat = 0;
        @(negedge clk);
        acc_in = v;
        acc_start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        acc_start = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (acc_done) begin
                lat = k + 1;
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_clear();
        @(negedge clk);
        acc_clear = 1'b1;
        @(negedge clk);
        acc_clear = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (acc_sum !== 32'h0 || acc_done !== 1'b0 || acc_busy !== 1'b0 || acc_overflow !== 1'b0)
            $display("FAIL reset: sum=%h done=%b busy=%b ovf=%b, expected 0/0/0/0", acc_sum, acc_done, acc_busy, acc_overflow);
        else passed++;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_first_add();
        int lat;
        do_op(32'h3FF00000, lat);
        total++;
        if (lat !== 4) $display("FAIL first_lat: got %0d expected 4", lat); else passed++;
        total++;
        if (acc_sum !== 32'h3FF00000 || acc_overflow !== 1'b0)
            $display("FAIL first_sum: got %h ovf=%b expected 3ff00000 ovf=0", acc_sum, acc_overflow);
        else passed++;
    endtask

    task automatic test_add_and_cancel_zero();
        int lat;
        do_op(32'h40C00000, lat);
        total++;
        if (lat !== 4) $display("FAIL add6_lat: got %0d expected 4", lat); else passed++;
        total++;
        if (acc_sum !== 32'h40FC0000) $display("FAIL add6_sum: got %h expected 40fc0000", acc_sum); else passed++;
        do_op(32'hC0FC0000, lat);
        total++;
        if (acc_sum !== 32'h00000000 || lat == 0)
            $display("FAIL zero_sum: got %h lat=%0d expected 00000000", acc_sum, lat);
        else passed++;
    endtask

    task automatic test_norm_shift();
        int lat;
        pulse_clear();
        do_op(32'h3FF00000, lat);
        do_op(32'hBFE00000, lat);
        total++;
        if (lat !== 7) $display("FAIL cancel_lat: got %0d expected 7", lat); else passed++;
        total++;
        if (acc_sum !== 32'h3E000000) $display("FAIL cancel_sum: got %h expected 3e000000", acc_sum); else passed++;
    endtask

    task automatic test_overflow();
        int lat;
        pulse_clear();
        do_op(32'h7F7FFFFF, lat);
        total++;
        if (acc_sum !== 32'h7F7FFFFF || acc_overflow !== 1'b0)
            $display("FAIL ovf_setup: got %h ovf=%b expected 7f7fffff ovf=0", acc_sum, acc_overflow);
        else passed++;
        do_op(32'h7F7FFFFF, lat);
        total++;
        if (acc_sum !== 32'h7F800000 || acc_overflow !== 1'b1 || lat !== 4)
            $display("FAIL ovf_sat: got %h ovf=%b lat=%0d expected 7f800000 ovf=1 lat=4", acc_sum, acc_overflow, lat);
        else passed++;
        do_op(32'h3F800000, lat);
        total++;
        if (acc_sum !== 32'h7F800000 || acc_overflow !== 1'b1 || lat == 0)
            $display("FAIL ovf_hold: got %h ovf=%b lat=%0d expected 7f800000 ovf=1 with done", acc_sum, acc_overflow, lat);
        else passed++;
        pulse_clear();
        #1;
        total++;
        if (acc_sum !== 32'h0 || acc_overflow !== 1'b0)
            $display("FAIL ovf_clear: got %h ovf=%b expected 00000000 ovf=0", acc_sum, acc_overflow);
        else passed++;
    endtask

    task automatic test_busy_ignore();
        int dones = 0;
        pulse_clear();
        @(negedge clk);
        acc_in = 32'h3F800000;
        acc_start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        total++;
        if (acc_busy !== 1'b1) $display("FAIL busy_align: got %b expected 1", acc_busy); else passed++;
        acc_in = 32'h40000000;
        acc_start = 1'b1;
        @(negedge clk);
        acc_start = 1'b0;
        for (int k = 0; k < 35; k++) begin
            @(posedge clk);
            #1;
            if (acc_done) dones++;
        end
        total++;
        if (dones !== 1 || acc_sum !== 32'h3F800000)
            $display("FAIL busy_ignore: dones=%0d sum=%h expected 1 and 3f800000", dones, acc_sum);
        else passed++;
    endtask

    task automatic test_clear_abort();
        int lat;
        int dones = 0;
        pulse_clear();
        do_op(32'h3FF00000, lat);
        @(negedge clk);
        acc_in = 32'hBFE00000;
        acc_start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        acc_start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        acc_clear = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if (acc_sum !== 32'h0 || acc_busy !== 1'b0 || acc_overflow !== 1'b0 || acc_done !== 1'b0)
            $display("FAIL clear_abort: sum=%h busy=%b ovf=%b done=%b expected 0/0/0/0", acc_sum, acc_busy, acc_overflow, acc_done);
        else passed++;
        @(negedge clk);
        acc_clear = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            if (acc_done) dones++;
        end
        total++;
        if (dones !== 0) $display("FAIL clear_nodone: dones=%0d expected 0", dones); else passed++;
    endtask

    task automatic test_rst_with_start();
        int lat;
        int dones = 0;
        do_op(32'h3F800000, lat);
        @(negedge clk);
        rst = 1'b1;
        acc_start = 1'b1;
        acc_in = 32'h40000000;
        @(negedge clk);
        rst = 1'b0;
        acc_start = 1'b0;
        for (int k = 0; k < 30; k++) begin
            @(posedge clk);
            #1;
            if (acc_done) dones++;
        end
        total++;
        if (dones !== 0 || acc_sum !== 32'h0 || acc_busy !== 1'b0)
            $display("FAIL rst_start: dones=%0d sum=%h busy=%b expected 0/00000000/0", dones, acc_sum, acc_busy);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_first_add();
        test_add_and_cancel_zero();
        test_norm_shift();
        test_overflow();
        test_busy_ignore();
        test_clear_abort();
        test_rst_with_start();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
